// File: rtl/fifo_byte_unpacker_if.sv
// fifo_byte_unpacker_if: bundles the FIFO read port and the byte stream of the
// unpacker into one interface.
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en is sampled
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO pop request
//   m_data     : byte output, MSB of the word first
//   m_valid    : m_data is valid
//   m_ready    : sink accepts the byte
//   m_last     : byte is the last one of its word
//   busy       : a word is being held or serialised
// Modports: master = unpacker side, slave = FIFO/sink (environment) side.
interface fifo_byte_unpacker_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output m_last,
    output busy
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  m_last,
    input  busy
  );
endinterface

// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pops DATA_W-bit words from a FIFO read port and emits
// them MSB first as bytes on a valid/ready stream. At most one FIFO read is in
// flight and the FIFO is never popped while it reports empty.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : fifo_byte_unpacker_if.master (FIFO read port + byte stream + busy)
// Optional feature: define FIFO_UNPACK_PREFETCH_EN to add a one-word prefetch
// slot that keeps the byte stream gap-free (1 byte/cycle sustained).
module fifo_byte_unpacker #(
  parameter int unsigned DATA_W = 24
) (
  input logic                 clk,
  input logic                 reset,
  fifo_byte_unpacker_if.master bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en;
  logic              send;
  logic              hs;
  logic              last_byte;

`ifdef FIFO_UNPACK_PREFETCH_EN
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              pf_full_q, pf_full_d;
  logic              pf_pend_q, pf_pend_d;
  logic              pf_pop;
`endif

  assign send      = (state_q == StSend);
  assign hs        = send && bus.m_ready;
  assign last_byte = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
`ifdef FIFO_UNPACK_PREFETCH_EN
    pf_data_d = pf_data_q;
    pf_full_d = pf_full_q;
    pf_pend_d = pf_pend_q;
    pf_pop    = 1'b0;
    // A prefetch read issued last cycle lands in the slot now.
    if (pf_pend_q) begin
      pf_data_d = bus.fifo_data;
      pf_full_d = 1'b1;
      pf_pend_d = 1'b0;
    end
`endif
    unique case (state_q)
      StIdle: begin
        rd_en = !bus.fifo_empty && !reset;
        if (rd_en) state_d = StLoad;
      end
      StLoad: begin
        sh_d    = bus.fifo_data;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
`ifdef FIFO_UNPACK_PREFETCH_EN
        pf_pop = !pf_full_q && !pf_pend_q && !bus.fifo_empty && !reset;
        rd_en  = pf_pop;
        if (pf_pop) pf_pend_d = 1'b1;
`endif
        if (hs) begin
          if (last_byte) begin
`ifdef FIFO_UNPACK_PREFETCH_EN
            if (pf_full_q) begin
              sh_d      = pf_data_q;
              cnt_d     = '0;
              pf_full_d = 1'b0;
            end else if (pf_pend_q) begin
              // Word arriving this cycle bypasses the slot.
              sh_d      = bus.fifo_data;
              cnt_d     = '0;
              pf_full_d = 1'b0;
            end else if (pf_pop) begin
              // Pop issued on the final byte: treat it as a normal load.
              state_d   = StLoad;
              pf_pend_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end else begin
            sh_d  = sh_q << 8;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
`ifdef FIFO_UNPACK_PREFETCH_EN
      pf_data_q <= '0;
      pf_full_q <= 1'b0;
      pf_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
`ifdef FIFO_UNPACK_PREFETCH_EN
      pf_data_q <= pf_data_d;
      pf_full_q <= pf_full_d;
      pf_pend_q <= pf_pend_d;
`endif
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = send;
  assign bus.m_data     = send ? sh_q[DATA_W-1 -: 8] : 8'h00;
  assign bus.m_last     = send && last_byte;
`ifdef FIFO_UNPACK_PREFETCH_EN
  assign bus.busy       = (state_q != StIdle) || pf_full_q;
`else
  assign bus.busy       = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Bench for fifo_byte_unpacker: a queue-based FIFO model with a one-cycle
// lagging empty flag feeds the DUT; every popped word is expanded into its
// expected bytes (MSB first, last flag on the final byte) and each stream
// handshake is checked against that byte queue.
module tb_fifo_byte_unpacker;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned BYTES  = DATA_W / 8;
`ifdef FIFO_UNPACK_PREFETCH_EN
  localparam int LAST_BYTE_CYC = 13;
`else
  localparam int LAST_BYTE_CYC = 19;
`endif

  logic clk = 1'b0;
  logic reset;

  fifo_byte_unpacker_if #(.DATA_W(DATA_W)) bus ();

  fifo_byte_unpacker #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq[$];
  logic [8:0]        exp_q[$];
  logic              fifo_err = 1'b0;
  int unsigned       fm_size;
  logic [DATA_W-1:0] fm_word;

  // FIFO model: registered read data, empty flag reflects the occupancy
  // before the pop, so it lags a pop by one cycle.
  always @(posedge clk) begin
    fm_size = fq.size();
    if (bus.fifo_rd_en) begin
      if (fm_size == 0) begin
        fifo_err <= 1'b1;
      end else begin
        fm_word = fq.pop_front();
        bus.fifo_data <= fm_word;
        for (int i = 0; i < int'(BYTES); i++)
          exp_q.push_back({(i == int'(BYTES) - 1), fm_word[DATA_W-1-8*i -: 8]});
      end
    end
    bus.fifo_empty <= (fm_size == 0);
  end

  int         n_checks;
  int         n_err;
  int         cyc;
  int         rd_count;
  logic       prev_valid, prev_ready, prev_reset, prev_rd, prev_last;
  logic [7:0] prev_data;
  logic [7:0] hs_bytes[$];
  int         hs_cycle[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fq.push_back(w);
  endtask

  // Observe one cycle at the falling edge and run the per-cycle rules.
  task automatic sample();
    logic [8:0] e;
    @(negedge clk);
    chk("rd_en_while_empty", bus.fifo_rd_en && bus.fifo_empty, 0);
    chk("back_to_back_pop", prev_rd && bus.fifo_rd_en, 0);
    chk("last_without_valid", bus.m_last && !bus.m_valid, 0);
    chk("busy", bus.busy, bus.m_valid || prev_rd);
    if (prev_valid && !prev_ready && !prev_reset) begin
      chk("stall_valid", bus.m_valid, 1);
      chk("stall_data", bus.m_data, prev_data);
      chk("stall_last", bus.m_last, prev_last);
    end
    if (bus.fifo_rd_en) rd_count++;
    if (reset) begin
      exp_q.delete();
    end else if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_byte", bus.m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("byte", bus.m_data, e[7:0]);
        chk("last", bus.m_last, e[8]);
      end
      hs_bytes.push_back(bus.m_data);
      hs_cycle.push_back(cyc);
    end
    prev_valid = bus.m_valid;
    prev_ready = bus.m_ready;
    prev_reset = reset;
    prev_rd    = bus.fifo_rd_en;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    int         c0;
    int         k;
    logic [5:0] pat;
    n_checks   = 0;
    n_err      = 0;
    cyc        = 0;
    rd_count   = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_reset = 1'b1;
    prev_rd    = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    reset      = 1'b1;
    bus.m_ready = 1'b0;
    advance();
    cycle();

    // Reset state, and no pop while reset is held even with data available.
    push(24'h5A5A5A);
    sample();
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 8'h00);
    chk("rst_last", bus.m_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    advance();
    sample();
    chk("rst_rd_en_nonempty", bus.fifo_rd_en, 0);
    advance();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    repeat (8) cycle();
    chk("rst_word_flushed", exp_q.size(), 0);

    // Empty FIFO: nothing happens.
    for (int i = 0; i < 50; i++) begin
      sample();
      chk("idle_rd_en", bus.fifo_rd_en, 0);
      chk("idle_valid", bus.m_valid, 0);
      chk("idle_busy", bus.busy, 0);
      advance();
    end

    // Single word latency and byte order.
    hs_bytes.delete();
    hs_cycle.delete();
    rd_count = 0;
    push(24'hA1B2C3);
    cycle();
    c0 = cyc;
    sample();
    chk("lat_rd_en_c0", bus.fifo_rd_en, 1);
    advance();
    sample();
    chk("lat_load_valid", bus.m_valid, 0);
    chk("lat_load_busy", bus.busy, 1);
    advance();
    repeat (6) cycle();
    chk("a1_count", hs_bytes.size(), 3);
    chk("a1_pops", rd_count, 1);
    if (hs_bytes.size() == 3) begin
      chk("a1_b0", hs_bytes[0], 8'hA1);
      chk("a1_b1", hs_bytes[1], 8'hB2);
      chk("a1_b2", hs_bytes[2], 8'hC3);
      chk("a1_t0", hs_cycle[0] - c0, 2);
      chk("a1_t2", hs_cycle[2] - c0, 4);
    end

    // Backpressure pattern 0,0,1,0,1,1 from the first valid cycle.
    hs_bytes.delete();
    pat = 6'b110100;
    push(24'h112233);
    bus.m_ready = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 6; i++) begin
      bus.m_ready = pat[i];
      cycle();
    end
    bus.m_ready = 1'b1;
    repeat (2) cycle();
    chk("bp_count", hs_bytes.size(), 3);
    if (hs_bytes.size() == 3) begin
      chk("bp_b0", hs_bytes[0], 8'h11);
      chk("bp_b1", hs_bytes[1], 8'h22);
      chk("bp_b2", hs_bytes[2], 8'h33);
    end

    // Four back-to-back words with the sink always ready.
    hs_bytes.delete();
    hs_cycle.delete();
    for (int w = 1; w <= 4; w++) push(DATA_W'(w));
    cycle();
    c0 = cyc;
    repeat (25) cycle();
    chk("burst_count", hs_bytes.size(), 12);
    if (hs_bytes.size() == 12) begin
      chk("burst_first", hs_cycle[0] - c0, 2);
      chk("burst_last", hs_cycle[11] - c0, LAST_BYTE_CYC);
      for (int i = 0; i < 12; i++)
        chk("burst_byte", hs_bytes[i], (i % 3 == 2) ? 8'(i / 3 + 1) : 8'h00);
    end

    // Reset while the second byte is on the bus.
    push(24'hDEADBE);
    repeat (4) cycle();
    reset = 1'b1;
    sample();
    chk("mid_valid", bus.m_valid, 1);
    chk("mid_data", bus.m_data, 8'hAD);
    advance();
    sample();
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_data", bus.m_data, 8'h00);
    chk("mid_rst_last", bus.m_last, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
    advance();
    reset = 1'b0;
    hs_bytes.delete();
    push(24'h778899);
    repeat (8) cycle();
    chk("post_rst_count", hs_bytes.size(), 3);
    if (hs_bytes.size() == 3) chk("post_rst_b0", hs_bytes[0], 8'h77);

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) push(DATA_W'($urandom()));
      bus.m_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0;
    bus.m_ready = 1'b1;
    k = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || bus.busy !== 1'b0) && k < 1500) begin
      cycle();
      k++;
    end
    chk("drain_in_time", k < 1500, 1);
    chk("no_lost_bytes", exp_q.size(), 0);
    chk("fifo_err", fifo_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
